// File: rtl/gshare_predictor_if.sv
// gshare_predictor_if
//   Fetch, resolve and prediction signals of the gshare direction predictor.
//   master : fetch/resolve source (drives instruction and resolution, reads prediction)
//   slave  : the predictor itself
//   Fetch    : Instr_input, Instr_addr_input
//   Resolve  : Branch_valid_IN, Branch_resolved, Branch_pred_IN, Branch_index_IN, Branch_hist_IN
//   Predict  : Is_branch, Branch_global_prediction, Pred_index, Pred_hist
interface gshare_predictor_if #(
    parameter int HIST_BITS = 10
);
    logic [31:0]          Instr_input;
    logic [31:0]          Instr_addr_input;
    logic                 Branch_valid_IN;
    logic                 Branch_resolved;
    logic                 Branch_pred_IN;
    logic [HIST_BITS-1:0] Branch_index_IN;
    logic [HIST_BITS-1:0] Branch_hist_IN;
    logic                 Is_branch;
    logic                 Branch_global_prediction;
    logic [HIST_BITS-1:0] Pred_index;
    logic [HIST_BITS-1:0] Pred_hist;

    modport master (
        output Instr_input, Instr_addr_input,
        output Branch_valid_IN, Branch_resolved, Branch_pred_IN,
        output Branch_index_IN, Branch_hist_IN,
        input  Is_branch, Branch_global_prediction, Pred_index, Pred_hist
    );

    modport slave (
        input  Instr_input, Instr_addr_input,
        input  Branch_valid_IN, Branch_resolved, Branch_pred_IN,
        input  Branch_index_IN, Branch_hist_IN,
        output Is_branch, Branch_global_prediction, Pred_index, Pred_hist
    );
endinterface

// File: rtl/gshare_predictor.sv
// gshare_predictor
//   Global-history direction predictor. Indexes a table of 2-bit saturating
//   counters with PC[HIST_BITS+1:2] XOR GHR, shifts the GHR speculatively on
//   every fetched conditional branch, trains at resolution and repairs the
//   GHR on a misprediction.
//   CLK   : clock, rising edge
//   RESET : asynchronous, active-low
//   bus   : gshare_predictor_if.slave (fetch, resolve, registered prediction)
module gshare_predictor #(
    parameter int HIST_BITS = 10
) (
    input  logic                  CLK,
    input  logic                  RESET,
    gshare_predictor_if.slave     bus
);
    localparam int PHT_SIZE = 1 << HIST_BITS;

    logic [1:0]           pht [PHT_SIZE];
    logic [HIST_BITS-1:0] ghr;
    logic [HIST_BITS-1:0] idx;
    logic                 is_br;
    logic                 pred_bit;
    logic                 repair;
    logic [1:0]           train_old;
    logic [1:0]           train_new;
    logic [5:0]           opcode;
    logic [4:0]           rt;

    logic                 is_branch_q;
    logic                 pred_q;
    logic [HIST_BITS-1:0] pred_index_q;
    logic [HIST_BITS-1:0] pred_hist_q;

    // Instruction and PC bits that play no part in decode or indexing.
    logic unused_bits;
    assign unused_bits = ^{bus.Instr_input[25:21], bus.Instr_input[15:0],
                           bus.Instr_addr_input[31:HIST_BITS+2],
                           bus.Instr_addr_input[1:0]};

    assign opcode = bus.Instr_input[31:26];
    assign rt     = bus.Instr_input[20:16];

    always_comb begin
        is_br = 1'b0;
        case (opcode)
            6'b000100, 6'b000101, 6'b000110, 6'b000111: is_br = 1'b1;
            6'b000001: is_br = (rt == 5'b00000) || (rt == 5'b00001) ||
                               (rt == 5'b10000) || (rt == 5'b10001);
            default:   is_br = 1'b0;
        endcase
    end

    assign idx      = bus.Instr_addr_input[HIST_BITS+1:2] ^ ghr;
    assign pred_bit = pht[idx][1];
    assign repair   = bus.Branch_valid_IN && (bus.Branch_resolved != bus.Branch_pred_IN);

    assign train_old = pht[bus.Branch_index_IN];
    always_comb begin
        train_new = train_old;
        if (bus.Branch_resolved) begin
            if (train_old != 2'b11) train_new = train_old + 2'b01;
        end else begin
            if (train_old != 2'b00) train_new = train_old - 2'b01;
        end
    end

    // Prediction outputs and GHR. A repair overrides the speculative shift of
    // a branch fetched in the same cycle (that branch is on the wrong path),
    // but its outputs are still produced from the pre-repair GHR.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ghr          <= '0;
            is_branch_q  <= 1'b0;
            pred_q       <= 1'b0;
            pred_index_q <= '0;
            pred_hist_q  <= '0;
        end else begin
            is_branch_q <= is_br;
            pred_q      <= is_br ? pred_bit : 1'b0;
            if (is_br) begin
                pred_index_q <= idx;
                pred_hist_q  <= ghr;
            end
            if (repair)
                ghr <= {bus.Branch_hist_IN[HIST_BITS-2:0], bus.Branch_resolved};
            else if (is_br)
                ghr <= {ghr[HIST_BITS-2:0], pred_bit};
        end
    end

    // Counter table; a same-cycle read of the trained entry sees the old value.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < PHT_SIZE; i++) pht[i] <= 2'b01;
        end else if (bus.Branch_valid_IN) begin
            pht[bus.Branch_index_IN] <= train_new;
        end
    end

    assign bus.Is_branch                = is_branch_q;
    assign bus.Branch_global_prediction = pred_q;
    assign bus.Pred_index               = pred_index_q;
    assign bus.Pred_hist                = pred_hist_q;
endmodule

// File: tb/tb_gshare_predictor.sv
module tb_gshare_predictor;
    localparam int HB = 10;
    localparam logic [31:0] ADDU   = 32'h0000_0021;
    localparam logic [31:0] BEQ    = 32'h1000_0000;
    localparam logic [31:0] BNE    = 32'h1400_0000;
    localparam logic [31:0] BLEZ   = 32'h1800_0000;
    localparam logic [31:0] BGTZ   = 32'h1C00_0000;
    localparam logic [31:0] BLTZ   = 32'h0400_0000;
    localparam logic [31:0] BGEZ   = 32'h0401_0000;
    localparam logic [31:0] BLTZAL = 32'h0410_0000;
    localparam logic [31:0] BGEZAL = 32'h0411_0000;
    localparam logic [31:0] RIMM2  = 32'h0402_0000;

    typedef struct {
        string         name;
        logic          isb;
        logic          pred;
        logic [HB-1:0] idx;
        logic [HB-1:0] hist;
    } exp_t;

    logic CLK = 1'b0;
    logic RESET = 1'b0;
    int   n_vec = 0;
    int   n_fail = 0;
    exp_t q[$];

    gshare_predictor_if #(.HIST_BITS(HB)) bus ();

    gshare_predictor #(.HIST_BITS(HB)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                         input logic bv, input logic res, input logic bp,
                         input logic [HB-1:0] bidx, input logic [HB-1:0] bhist);
        bus.Instr_input      = ins;
        bus.Instr_addr_input = pc;
        bus.Branch_valid_IN  = bv;
        bus.Branch_resolved  = res;
        bus.Branch_pred_IN   = bp;
        bus.Branch_index_IN  = bidx;
        bus.Branch_hist_IN   = bhist;
    endtask

    task automatic step(input string name,
                        input logic [31:0] ins, input logic [31:0] pc,
                        input logic bv, input logic res, input logic bp,
                        input logic [HB-1:0] bidx, input logic [HB-1:0] bhist,
                        input logic e_isb, input logic e_pred,
                        input logic [HB-1:0] e_idx, input logic [HB-1:0] e_hist);
        exp_t e;
        @(negedge CLK);
        drive(ins, pc, bv, res, bp, bidx, bhist);
        e.name = name; e.isb = e_isb; e.pred = e_pred; e.idx = e_idx; e.hist = e_hist;
        q.push_back(e);
    endtask

    task automatic check_zero(input string name);
        n_vec++;
        if (bus.Is_branch !== 1'b0 || bus.Branch_global_prediction !== 1'b0 ||
            bus.Pred_index !== '0 || bus.Pred_hist !== '0) begin
            n_fail++;
            $display("FAIL %s: got isb=%b pred=%b idx=%h hist=%h, want all zero",
                     name, bus.Is_branch, bus.Branch_global_prediction,
                     bus.Pred_index, bus.Pred_hist);
        end
    endtask

    initial begin
        fork
            forever begin
                exp_t e;
                @(posedge CLK);
                #1;
                if (q.size() != 0) begin
                    e = q.pop_front();
                    n_vec++;
                    if (bus.Is_branch !== e.isb || bus.Branch_global_prediction !== e.pred ||
                        bus.Pred_index !== e.idx || bus.Pred_hist !== e.hist) begin
                        n_fail++;
                        $display("FAIL %s: got isb=%b pred=%b idx=%h hist=%h, want isb=%b pred=%b idx=%h hist=%h",
                                 e.name, bus.Is_branch, bus.Branch_global_prediction,
                                 bus.Pred_index, bus.Pred_hist, e.isb, e.pred, e.idx, e.hist);
                    end
                end
            end
        join_none

        drive(ADDU, 32'h0, 1'b0, 1'b0, 1'b0, '0, '0);
        repeat (3) @(negedge CLK);
        check_zero("reset_outputs");
        RESET = 1'b1;

        //    name          instr   pc            bv res bp bidx    bhist    isb pred idx     hist
        step("beq_cold",    BEQ,    32'h0040_0010, 0, 0, 0, 10'h000, 10'h000, 1, 0, 10'h004, 10'h000);
        step("addu",        ADDU,   32'h0040_0014, 0, 0, 0, 10'h000, 10'h000, 0, 0, 10'h004, 10'h000);
        step("regimm_rt2",  RIMM2,  32'h0040_0018, 0, 0, 0, 10'h000, 10'h000, 0, 0, 10'h004, 10'h000);
        step("train_t1",    ADDU,   32'h0040_001C, 1, 1, 1, 10'h004, 10'h000, 0, 0, 10'h004, 10'h000);
        step("train_t2",    ADDU,   32'h0040_001C, 1, 1, 1, 10'h004, 10'h000, 0, 0, 10'h004, 10'h000);
        step("train_t3",    ADDU,   32'h0040_001C, 1, 1, 1, 10'h004, 10'h000, 0, 0, 10'h004, 10'h000);
        step("beq_trained", BEQ,    32'h0040_0010, 0, 0, 0, 10'h000, 10'h000, 1, 1, 10'h004, 10'h000);
        step("bne_ghr1",    BNE,    32'h0040_0010, 0, 0, 0, 10'h000, 10'h000, 1, 0, 10'h005, 10'h001);
        step("blez_ghr2",   BLEZ,   32'h0040_0020, 0, 0, 0, 10'h000, 10'h000, 1, 0, 10'h00A, 10'h002);
        step("repair_only", ADDU,   32'h0040_0024, 1, 1, 0, 10'h3FF, 10'h155, 0, 0, 10'h00A, 10'h002);
        step("bgtz_2ab",    BGTZ,   32'h0040_0000, 0, 0, 0, 10'h000, 10'h000, 1, 0, 10'h2AB, 10'h2AB);
        step("bne_repair",  BNE,    32'h0040_0000, 1, 0, 1, 10'h100, 10'h0F0, 1, 0, 10'h156, 10'h156);
        step("bltz_1e0",    BLTZ,   32'h0040_0000, 0, 0, 0, 10'h000, 10'h000, 1, 0, 10'h1E0, 10'h1E0);
        step("bgez_rdwr",   BGEZ,   32'h0040_00FC, 1, 0, 0, 10'h3FF, 10'h000, 1, 1, 10'h3FF, 10'h3C0);
        step("bltzal_new",  BLTZAL, 32'h0040_01F8, 0, 0, 0, 10'h000, 10'h000, 1, 0, 10'h3FF, 10'h381);
        step("bgezal_302",  BGEZAL, 32'h0040_0000, 0, 0, 0, 10'h000, 10'h000, 1, 0, 10'h302, 10'h302);

        @(posedge CLK);
        #3;
        RESET = 1'b0;
        #1;
        check_zero("async_reset");
        drive(ADDU, 32'h0, 1'b0, 1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge CLK);
        check_zero("reset_hold");
        RESET = 1'b1;

        step("beq_postrst", BEQ,    32'h0040_0010, 0, 0, 0, 10'h000, 10'h000, 1, 0, 10'h004, 10'h000);
        step("train_once",  ADDU,   32'h0040_0014, 1, 1, 1, 10'h004, 10'h000, 0, 0, 10'h004, 10'h000);
        step("beq_weak_t",  BEQ,    32'h0040_0010, 0, 0, 0, 10'h000, 10'h000, 1, 1, 10'h004, 10'h000);
        @(negedge CLK);
        drive(ADDU, 32'h0, 1'b0, 1'b0, 1'b0, '0, '0);

        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge CLK);
        if (q.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
